// File: rtl/mpu_pkg.sv
// Opcode constants, ALU output-mux encodings and controller state encoding
// shared by the mpu_ctrl block and its beat counter.
package mpu_pkg;

  localparam logic [3:0] OP_LOAD   = 4'b0100;
  localparam logic [3:0] OP_COPY   = 4'b0101;
  localparam logic [3:0] OP_UNLOAD = 4'b0110;
  localparam logic [3:0] OP_CLEAR  = 4'b0111;

  // Opcode class lives in op[3:2].
  localparam logic [1:0] OPC_NOP = 2'b00;
  localparam logic [1:0] OPC_MEM = 2'b01;
  localparam logic [1:0] OPC_ILL = 2'b10;
  localparam logic [1:0] OPC_ALU = 2'b11;

  localparam logic [1:0] MUX_ADD   = 2'b00;
  localparam logic [1:0] MUX_SHIFT = 2'b01;
  localparam logic [1:0] MUX_SUB   = 2'b10;
  localparam logic [1:0] MUX_MULT  = 2'b11;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_EXEC,
    ST_LOAD,
    ST_UNLOAD,
    ST_COPY,
    ST_CLEAR
  } state_e;

  function automatic logic [1:0] alu_mux(input logic [3:0] op);
    case (op[1:0])
      2'b00:   return MUX_ADD;
      2'b01:   return MUX_SHIFT;
      2'b10:   return MUX_SUB;
      default: return MUX_MULT;
    endcase
  endfunction

endpackage

// File: rtl/mpu_beat_cnt.sv
// Beat counter for host LOAD/UNLOAD transfers: tracks the beat index,
// exposes its bit offset and flags the terminal beat.
module mpu_beat_cnt #(
  parameter int NBEATS    = 64,
  parameter int BEAT_BITS = 8,
  parameter int OFF_W     = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             adv,
  output logic [OFF_W-1:0] offset,
  output logic             last
);

  localparam int CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBEATS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last   = (cnt_q == CNT_LAST);
  assign offset = OFF_W'(cnt_q) * OFF_W'(BEAT_BITS);

  // The terminal beat returns the count to zero so the offset never wraps mid-transfer.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (adv) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mpu_ctrl.sv
// Matrix-processing-unit instruction controller: sequences ALU, copy, clear and
// host LOAD/UNLOAD operations over NUM_BRAMS banks. Define MPU_CTRL_PERF_EN for
// the op_count / busy_cycles performance counters.
module mpu_ctrl
  import mpu_pkg::*;
#(
  parameter int NUM_BRAMS = 4,
  parameter int DATA_BITS = 512,
  parameter int BEAT_BITS = 8,
  parameter int ALU_LAT   = 1,
  localparam int SEL_W    = $clog2(NUM_BRAMS),
  localparam int OFF_W    = $clog2(DATA_BITS),
  localparam int NBEATS   = DATA_BITS / BEAT_BITS,
  localparam int IW       = 4 + 2 * SEL_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IW-1:0]        instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 host_valid,
  input  logic                 host_ready,
  output logic                 beat_valid,
  output logic [OFF_W-1:0]     offset,
  output logic [SEL_W-1:0]     aa_sel,
  output logic [SEL_W-1:0]     dd_sel,
  output logic [1:0]           out_mux,
  output logic                 bram_in_mux,
  output logic [NUM_BRAMS-1:0] bram_wr_en,
  output logic [NUM_BRAMS-1:0] bram_byte_en,
  output logic [NUM_BRAMS-1:0] bram_rst,
  output logic                 busy,
  output logic                 done,
`ifdef MPU_CTRL_PERF_EN
  output logic [15:0]          op_count,
  output logic [31:0]          busy_cycles,
`endif
  output logic                 illegal
);

  localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     aa_q, aa_d, dd_q, dd_d;
  logic [1:0]           mux_q, mux_d;
  logic [3:0]           lat_q, lat_d;
  logic                 illegal_q, illegal_d;
  logic                 cnt_clr, cnt_adv, cnt_last;
  logic [NUM_BRAMS-1:0] dd_oh;
  logic [3:0]           op;
  logic [SEL_W-1:0]     instr_dd, instr_aa;

  assign op       = instr[3:0];
  assign instr_dd = instr[IW-1 -: SEL_W];
  assign instr_aa = instr[IW-1-SEL_W -: SEL_W];
  assign dd_oh    = NUM_BRAMS'(1) << dd_q;

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = ~instr_ready;
  assign aa_sel      = aa_q;
  assign dd_sel      = dd_q;
  assign out_mux     = mux_q;
  assign illegal     = illegal_q;

  mpu_beat_cnt #(
    .NBEATS    (NBEATS),
    .BEAT_BITS (BEAT_BITS),
    .OFF_W     (OFF_W)
  ) u_beat_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .adv     (cnt_adv),
    .offset  (offset),
    .last    (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    aa_d         = aa_q;
    dd_d         = dd_q;
    mux_d        = mux_q;
    lat_d        = lat_q;
    illegal_d    = 1'b0;
    cnt_clr      = 1'b1;
    cnt_adv      = 1'b0;
    beat_valid   = 1'b0;
    bram_in_mux  = 1'b0;
    bram_wr_en   = '0;
    bram_byte_en = '0;
    bram_rst     = '0;
    done         = 1'b0;

    case (state_q)
      // Bank clear is held off while reset_n is still low so it fires only on the release cycle.
      ST_RESET: begin
        bram_rst = {NUM_BRAMS{reset_n}};
        state_d  = ST_IDLE;
      end
      ST_IDLE: begin
        if (instr_valid) begin
          aa_d = instr_aa;
          dd_d = instr_dd;
          case (op[3:2])
            OPC_NOP: begin end
            OPC_ILL: illegal_d = 1'b1;
            OPC_ALU: begin
              mux_d   = alu_mux(op);
              lat_d   = LAT_LAST;
              state_d = ST_EXEC;
            end
            default: begin
              case (op)
                OP_LOAD:   state_d = ST_LOAD;
                OP_COPY:   state_d = ST_COPY;
                OP_UNLOAD: state_d = ST_UNLOAD;
                OP_CLEAR:  state_d = ST_CLEAR;
                default:   begin end
              endcase
            end
          endcase
        end
      end
      ST_EXEC: begin
        if (lat_q == '0) begin
          bram_wr_en = dd_oh;
          done       = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_COPY: begin
        bram_in_mux = 1'b1;
        bram_wr_en  = dd_oh;
        done        = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_CLEAR: begin
        bram_rst = dd_oh;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_LOAD: begin
        cnt_clr = 1'b0;
        if (host_valid) begin
          bram_byte_en = dd_oh;
          cnt_adv      = 1'b1;
          if (cnt_last) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_UNLOAD: begin
        cnt_clr    = 1'b0;
        beat_valid = 1'b1;
        if (host_ready) begin
          cnt_adv = 1'b1;
          if (cnt_last) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_RESET;
      aa_q      <= '0;
      dd_q      <= '0;
      mux_q     <= MUX_ADD;
      lat_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aa_q      <= aa_d;
      dd_q      <= dd_d;
      mux_q     <= mux_d;
      lat_q     <= lat_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef MPU_CTRL_PERF_EN
  logic [15:0] op_count_q, op_count_d;
  logic [31:0] busy_cycles_q, busy_cycles_d;

  // op_count saturates; busy_cycles is allowed to wrap.
  always_comb begin
    op_count_d    = op_count_q;
    busy_cycles_d = busy_cycles_q;
    if (done && (op_count_q != 16'hFFFF)) op_count_d = op_count_q + 16'd1;
    if (busy) busy_cycles_d = busy_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_count_q    <= '0;
      busy_cycles_q <= '0;
    end else begin
      op_count_q    <= op_count_d;
      busy_cycles_q <= busy_cycles_d;
    end
  end

  assign op_count    = op_count_q;
  assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_mpu_ctrl.sv
// Self-checking bench for mpu_ctrl: table-driven short ops, hand-written
// LOAD/UNLOAD/reset sequences and randomized ops against a transaction model.
module tb_mpu_ctrl;

  localparam int NB     = 4;
  localparam int DB     = 512;
  localparam int BB     = 8;
  localparam int LAT    = 3;
  localparam int NBEATS = DB / BB;

  localparam int K_NOP    = 0;
  localparam int K_ILL    = 1;
  localparam int K_ALU    = 2;
  localparam int K_LOAD   = 3;
  localparam int K_COPY   = 4;
  localparam int K_UNLOAD = 5;
  localparam int K_CLEAR  = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          host_valid;
  logic          host_ready;
  logic          beat_valid;
  logic [8:0]    offset;
  logic [1:0]    aa_sel;
  logic [1:0]    dd_sel;
  logic [1:0]    out_mux;
  logic          bram_in_mux;
  logic [NB-1:0] bram_wr_en;
  logic [NB-1:0] bram_byte_en;
  logic [NB-1:0] bram_rst;
  logic          busy;
  logic          done;
  logic          illegal;
`ifdef MPU_CTRL_PERF_EN
  logic [15:0]   op_count;
  logic [31:0]   busy_cycles;
`endif

  always #5 clk = ~clk;

  mpu_ctrl #(
    .NUM_BRAMS (NB),
    .DATA_BITS (DB),
    .BEAT_BITS (BB),
    .ALU_LAT   (LAT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .beat_valid   (beat_valid),
    .offset       (offset),
    .aa_sel       (aa_sel),
    .dd_sel       (dd_sel),
    .out_mux      (out_mux),
    .bram_in_mux  (bram_in_mux),
    .bram_wr_en   (bram_wr_en),
    .bram_byte_en (bram_byte_en),
    .bram_rst     (bram_rst),
    .busy         (busy),
    .done         (done),
`ifdef MPU_CTRL_PERF_EN
    .op_count     (op_count),
    .busy_cycles  (busy_cycles),
`endif
    .illegal      (illegal)
  );

  int total = 0;
  int bad   = 0;
  int cur_k = 0;
  logic [1:0] mux_m = 2'b00;

  int       obs_done_k, obs_done_cnt, obs_ill, obs_pulses, obs_stall80;
  logic [3:0] obs_wr, obs_rst;
  logic     obs_inmux;
  logic [8:0] obs_last_off;

  typedef struct {
    logic [3:0] op;
    logic [1:0] dd;
    logic [1:0] aa;
    int         done_k;
    logic [3:0] wr;
    logic [3:0] rst;
    logic       inmux;
    int         ill;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (k=%0d): got %0h expected %0h", name, cur_k, act, exp);
    end
  endtask

  function automatic int op_kind(input logic [3:0] op);
    if (op[3:2] == 2'b00) return K_NOP;
    if (op[3:2] == 2'b10) return K_ILL;
    if (op[3:2] == 2'b11) return K_ALU;
    case (op[1:0])
      2'b00:   return K_LOAD;
      2'b01:   return K_COPY;
      2'b10:   return K_UNLOAD;
      default: return K_CLEAR;
    endcase
  endfunction

  // hmode: 0 always active, 1 toggle starting active, 2 random, 3 stall 3 cycles at beat 10
  task automatic run_op(input logic [3:0] op, input logic [1:0] dd, input logic [1:0] aa,
                        input int hmode, input bit junk);
    int kind, beats, stall, k;
    bit fin, hv;
    logic [3:0] oh, e_wr, e_rst, e_byte;
    logic e_inmux, e_bv, e_done, e_ill, e_rdy;
    logic [8:0] e_off;
    oh   = 4'b0001 << dd;
    kind = op_kind(op);
    obs_done_k = 0; obs_done_cnt = 0; obs_ill = 0; obs_pulses = 0; obs_stall80 = 0;
    obs_wr = '0; obs_rst = '0; obs_inmux = 1'b0; obs_last_off = '0;
    cur_k = 0;
    instr = {dd, aa, op};
    instr_valid = 1'b1;
    host_valid = 1'b0;
    host_ready = 1'b0;
    @(negedge clk);
    chk("accept instr_ready", instr_ready, 1'b1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (kind == K_ALU) mux_m = op[1:0];
    beats = 0; stall = 0; fin = 1'b0; k = 0;
    while (!fin && k < 2000) begin
      k++;
      cur_k = k;
      case (hmode)
        0: hv = 1'b1;
        1: hv = (k % 2) == 1;
        2: hv = $urandom_range(0, 3) != 0;
        default: begin
          if (beats == 10 && stall < 3) begin
            hv = 1'b0;
            stall++;
          end else begin
            hv = 1'b1;
          end
        end
      endcase
      e_wr = '0; e_rst = '0; e_byte = '0; e_inmux = 1'b0; e_bv = 1'b0;
      e_done = 1'b0; e_ill = 1'b0; e_rdy = 1'b0; e_off = '0;
      case (kind)
        K_NOP: begin e_rdy = 1'b1; fin = 1'b1; end
        K_ILL: begin e_ill = 1'b1; e_rdy = 1'b1; fin = 1'b1; end
        K_ALU: begin
          if (k == LAT) begin e_wr = oh; e_done = 1'b1; end
          else if (k > LAT) begin e_rdy = 1'b1; fin = 1'b1; end
        end
        K_COPY: begin
          if (k == 1) begin e_wr = oh; e_inmux = 1'b1; e_done = 1'b1; end
          else begin e_rdy = 1'b1; fin = 1'b1; end
        end
        K_CLEAR: begin
          if (k == 1) begin e_rst = oh; e_done = 1'b1; end
          else begin e_rdy = 1'b1; fin = 1'b1; end
        end
        default: begin
          if (beats < NBEATS) begin
            e_off = 9'(beats * BB);
            e_bv  = (kind == K_UNLOAD);
            if (hv) begin
              beats++;
              e_done = (beats == NBEATS);
              if (kind == K_LOAD) e_byte = oh;
            end
          end else begin
            e_rdy = 1'b1;
            fin   = 1'b1;
          end
        end
      endcase
      host_valid = (kind == K_LOAD)   ? hv : 1'($urandom_range(0, 1));
      host_ready = (kind == K_UNLOAD) ? hv : 1'($urandom_range(0, 1));
      if (junk && !e_rdy) begin
        instr = 8'($urandom);
        instr_valid = 1'b1;
      end else begin
        instr_valid = 1'b0;
      end
      @(negedge clk);
      chk("instr_ready", instr_ready, e_rdy);
      chk("busy", busy, !e_rdy);
      chk("done", done, e_done);
      chk("illegal", illegal, e_ill);
      chk("bram_wr_en", bram_wr_en, e_wr);
      chk("bram_byte_en", bram_byte_en, e_byte);
      chk("bram_rst", bram_rst, e_rst);
      chk("bram_in_mux", bram_in_mux, e_inmux);
      chk("beat_valid", beat_valid, e_bv);
      chk("offset", offset, e_off);
      chk("dd_sel", dd_sel, dd);
      chk("aa_sel", aa_sel, aa);
      chk("out_mux", out_mux, mux_m);
      if (done) begin
        obs_done_cnt++;
        if (obs_done_k == 0) obs_done_k = k;
      end
      obs_wr    |= bram_wr_en;
      obs_rst   |= bram_rst;
      obs_inmux |= bram_in_mux;
      obs_ill   += int'(illegal);
      if (bram_byte_en != '0 || (beat_valid && host_ready)) begin
        obs_pulses++;
        obs_last_off = offset;
      end
      if (beat_valid && !host_ready && offset == 9'd80) obs_stall80++;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    host_valid  = 1'b0;
    host_ready  = 1'b0;
    chk("op finished within budget", fin, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    tbl[0] = '{4'b0000, 2'd1, 2'd2, 0, 4'b0000, 4'b0000, 1'b0, 0};
    tbl[1] = '{4'b0011, 2'd3, 2'd0, 0, 4'b0000, 4'b0000, 1'b0, 0};
    tbl[2] = '{4'b1001, 2'd3, 2'd1, 0, 4'b0000, 4'b0000, 1'b0, 1};
    tbl[3] = '{4'b1010, 2'd0, 2'd0, 0, 4'b0000, 4'b0000, 1'b0, 1};
    tbl[4] = '{4'b0101, 2'd3, 2'd0, 1, 4'b1000, 4'b0000, 1'b1, 0};
    tbl[5] = '{4'b0111, 2'd0, 2'd2, 1, 4'b0000, 4'b0001, 1'b0, 0};
    tbl[6] = '{4'b1100, 2'd2, 2'd1, 3, 4'b0100, 4'b0000, 1'b0, 0};
    tbl[7] = '{4'b1101, 2'd0, 2'd3, 3, 4'b0001, 4'b0000, 1'b0, 0};
    tbl[8] = '{4'b1110, 2'd1, 2'd0, 3, 4'b0010, 4'b0000, 1'b0, 0};
    tbl[9] = '{4'b1111, 2'd3, 2'd3, 3, 4'b1000, 4'b0000, 1'b0, 0};

    reset_n = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    host_valid = 1'b0;
    host_ready = 1'b0;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset instr_ready", instr_ready, 1'b0);
    chk("reset busy", busy, 1'b1);
    chk("reset bram_rst", bram_rst, 4'b0000);
    chk("reset done", done, 1'b0);
    chk("reset illegal", illegal, 1'b0);
    chk("reset offset", offset, 9'd0);
    chk("reset dd_sel", dd_sel, 2'd0);
    chk("reset out_mux", out_mux, 2'b00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("release bram_rst", bram_rst, 4'b1111);
    chk("release instr_ready", instr_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle instr_ready", instr_ready, 1'b1);
    chk("idle bram_rst", bram_rst, 4'b0000);
    @(posedge clk); #1;

    // Short ops from the table, with junk instructions offered while busy
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].dd, tbl[i].aa, 2, 1'b1);
      chk("tbl done cycle", obs_done_k, tbl[i].done_k);
      chk("tbl wr_en", obs_wr, tbl[i].wr);
      chk("tbl bram_rst", obs_rst, tbl[i].rst);
      chk("tbl in_mux", obs_inmux, tbl[i].inmux);
      chk("tbl illegal", obs_ill, tbl[i].ill);
    end

    // LOAD dd=2 with host_valid toggling
    run_op(4'b0100, 2'd2, 2'd0, 1, 1'b1);
    chk("load byte_en pulses", obs_pulses, 64);
    chk("load done count", obs_done_cnt, 1);
    chk("load last offset", obs_last_off, 9'd504);

    // UNLOAD with host_ready low for 3 cycles at beat 10
    run_op(4'b0110, 2'd1, 2'd3, 3, 1'b0);
    chk("unload beats", obs_pulses, 64);
    chk("unload done count", obs_done_cnt, 1);
    chk("unload stall at 80", obs_stall80, 3);

    // Reset during LOAD beat 20
    cur_k = 0;
    dcount = 0;
    instr = {2'd3, 2'd1, 4'b0100};
    instr_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    host_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dcount += int'(done);
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid-load offset", offset, 9'd160);
    chk("mid-load byte_en", bram_byte_en, 4'b1000);
    dcount += int'(done);
    @(posedge clk); #1;
    reset_n = 1'b1;
    host_valid = 1'b0;
    @(negedge clk);
    dcount += int'(done);
    chk("abort bram_rst", bram_rst, 4'b1111);
    chk("abort instr_ready", instr_ready, 1'b0);
    chk("abort offset", offset, 9'd0);
    chk("abort dd_sel", dd_sel, 2'd0);
    @(posedge clk); #1;
    @(negedge clk);
    dcount += int'(done);
    chk("after abort instr_ready", instr_ready, 1'b1);
    chk("after abort bram_rst", bram_rst, 4'b0000);
    chk("after abort offset", offset, 9'd0);
    chk("aborted load done pulses", dcount, 0);
    mux_m = 2'b00;
    @(posedge clk); #1;

    // Randomized ops
    for (int i = 0; i < 25; i++) begin
      logic [3:0] rop;
      logic [1:0] rdd, raa;
      bit rj;
      rop = 4'($urandom_range(0, 15));
      rdd = 2'($urandom_range(0, 3));
      raa = 2'($urandom_range(0, 3));
      rj  = 1'($urandom_range(0, 1));
      run_op(rop, rdd, raa, 2, rj);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
